gmsk_burst_feeder: RTL and testbench

- Upstream neighbour of the GMSK I/Q modulator. Buffers burst data bits from the framing logic and optionally differentially encodes them.
- Presents one bit per symbol on next_symbol, paced by the modulator's symbol_strobe.
- Sequences each burst as IDLE fill -> payload -> guard fill and flags underruns.

---
 rtl/gmsk_burst_feeder.sv | 187 ++++++++++++++++++
 tb/tb_gmsk_burst_feeder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gmsk_burst_feeder.sv
// gmsk_burst_feeder: buffers framed burst bits in a FIFO and feeds the GMSK
// modulator one symbol per rising edge of symbol_strobe. Each burst runs
// IDLE fill -> BURST_BITS payload symbols -> GUARD_BITS fill symbols.
//
// Optional feature: define GMSK_DIFF_ENCODE_EN to enable GSM differential
// encoding (d_hat = d ^ d_prev). Without it next_symbol carries the raw bit.
//
// Ports:
//   clock, reset        posedge clock, asynchronous active-high reset
//   bit_in, bit_valid   upstream bit stream; accepted when bit_ready is high
//   bit_ready           FIFO not full
//   burst_start         single-cycle request to start a burst (IDLE only)
//   symbol_strobe       modulator symbol pacing, rising edge used
//   next_symbol         symbol bit, updated one clock after a strobe edge
//   burst_active        high during payload and guard
//   burst_done          one-clock pulse when guard ends
//   underrun, underrun_clear  sticky empty-FIFO flag and its clear
//   fifo_level          FIFO occupancy
module gmsk_burst_feeder #(
    parameter int unsigned FIFO_ADDR_BITS = 8,
    parameter int unsigned BURST_BITS     = 148,
    parameter int unsigned GUARD_BITS     = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    output logic                      bit_ready,
    input  logic                      burst_start,
    input  logic                      symbol_strobe,
    output logic                      next_symbol,
    output logic                      burst_active,
    output logic                      burst_done,
    output logic                      underrun,
    input  logic                      underrun_clear,
    output logic [FIFO_ADDR_BITS:0]   fifo_level
);

    localparam int unsigned DEPTH       = 1 << FIFO_ADDR_BITS;
    localparam int unsigned PTR_W       = FIFO_ADDR_BITS + 1;
    localparam int unsigned BIT_CNT_W   = $clog2(BURST_BITS);
    localparam int unsigned GUARD_CNT_W = $clog2(GUARD_BITS) + 1;
    localparam logic [BIT_CNT_W-1:0]   LAST_BIT   = BIT_CNT_W'(BURST_BITS - 1);
    localparam logic [GUARD_CNT_W-1:0] LAST_GUARD = GUARD_CNT_W'(GUARD_BITS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        GUARD   = 2'd2
    } state_t;

    state_t                  state, state_n;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [BIT_CNT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [GUARD_CNT_W-1:0]  guard_cnt, guard_cnt_n;
    logic                    strobe_q;
    logic                    next_symbol_n, burst_done_n, underrun_n;
    logic                    sym_edge, empty, full, push, pop;
    logic                    emit, sym_bit;
    logic                    mem [DEPTH];
`ifdef GMSK_DIFF_ENCODE_EN
    logic                    d_prev, d_prev_n;
`endif

    // FIFO status from pointers; the extra MSB separates full from empty.
    assign sym_edge = symbol_strobe && !strobe_q;
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[FIFO_ADDR_BITS] != rd_ptr[FIFO_ADDR_BITS]) &&
                      (wr_ptr[FIFO_ADDR_BITS-1:0] == rd_ptr[FIFO_ADDR_BITS-1:0]);
    assign push     = bit_valid && !full;
    assign pop      = (state == PAYLOAD) && sym_edge && !empty;

    assign bit_ready    = !full;
    assign fifo_level   = wr_ptr - rd_ptr;
    assign burst_active = (state != IDLE);

    // Storage array, no reset needed.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr[FIFO_ADDR_BITS-1:0]] <= bit_in;
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            bit_cnt     <= '0;
            guard_cnt   <= '0;
            strobe_q    <= 1'b0;
            next_symbol <= 1'b0;
            burst_done  <= 1'b0;
            underrun    <= 1'b0;
`ifdef GMSK_DIFF_ENCODE_EN
            d_prev      <= 1'b1;
`endif
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            bit_cnt     <= bit_cnt_n;
            guard_cnt   <= guard_cnt_n;
            strobe_q    <= symbol_strobe;
            next_symbol <= next_symbol_n;
            burst_done  <= burst_done_n;
            underrun    <= underrun_n;
`ifdef GMSK_DIFF_ENCODE_EN
            d_prev      <= d_prev_n;
`endif
        end
    end

    // Burst sequencing, symbol selection and encoding.
    always_comb begin
        state_n       = state;
        bit_cnt_n     = bit_cnt;
        guard_cnt_n   = guard_cnt;
        next_symbol_n = next_symbol;
        burst_done_n  = 1'b0;
        underrun_n    = underrun && !underrun_clear;
        emit          = 1'b0;
        sym_bit       = 1'b1;
        wr_ptr_n      = wr_ptr + PTR_W'(push);
        rd_ptr_n      = rd_ptr + PTR_W'(pop);
`ifdef GMSK_DIFF_ENCODE_EN
        d_prev_n      = d_prev;
`endif

        case (state)
            IDLE: begin
                emit = sym_edge;
                if (burst_start) begin
                    state_n   = PAYLOAD;
                    bit_cnt_n = '0;
                end
            end
            PAYLOAD: begin
                if (sym_edge) begin
                    emit = 1'b1;
                    // Empty FIFO: send fill but keep counting so burst length holds.
                    if (empty) begin
                        underrun_n = 1'b1;
                    end else begin
                        sym_bit = mem[rd_ptr[FIFO_ADDR_BITS-1:0]];
                    end
                    if (bit_cnt == LAST_BIT) begin
                        state_n     = GUARD;
                        guard_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                    end
                end
            end
            GUARD: begin
                if (sym_edge) begin
                    emit = 1'b1;
                    if (guard_cnt == LAST_GUARD) begin
                        state_n      = IDLE;
                        burst_done_n = 1'b1;
                    end else begin
                        guard_cnt_n = guard_cnt + GUARD_CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (emit) begin
`ifdef GMSK_DIFF_ENCODE_EN
            next_symbol_n = sym_bit ^ d_prev;
            d_prev_n      = sym_bit;
`else
            next_symbol_n = sym_bit;
`endif
        end

`ifdef GMSK_DIFF_ENCODE_EN
        // Encoder history restarts at each payload.
        if ((state == IDLE) && burst_start) begin
            d_prev_n = 1'b1;
        end
`endif
    end

endmodule

// File: tb/tb_gmsk_burst_feeder.sv
// Testbench for gmsk_burst_feeder: directed burst scenarios with random data,
// checked every clock against a queue-based symbol model.
module tb_gmsk_burst_feeder;

    localparam int DEPTH = 256;
    localparam int BURST = 148;
    localparam int GUARD = 8;
`ifdef GMSK_DIFF_ENCODE_EN
    localparam bit DIFF = 1'b1;
`else
    localparam bit DIFF = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic       burst_start = 1'b0;
    logic       symbol_strobe = 1'b0;
    logic       next_symbol;
    logic       burst_active;
    logic       burst_done;
    logic       underrun;
    logic       underrun_clear = 1'b0;
    logic [8:0] fifo_level;

    gmsk_burst_feeder dut (
        .clock          (clock),
        .reset          (reset),
        .bit_in         (bit_in),
        .bit_valid      (bit_valid),
        .bit_ready      (bit_ready),
        .burst_start    (burst_start),
        .symbol_strobe  (symbol_strobe),
        .next_symbol    (next_symbol),
        .burst_active   (burst_active),
        .burst_done     (burst_done),
        .underrun       (underrun),
        .underrun_clear (underrun_clear),
        .fifo_level     (fifo_level)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: queue of buffered bits plus position inside the burst.
    bit q[$];
    int m_pos;          // -1 outside a burst, else symbol index 0..BURST+GUARD-1
    bit m_prev;
    bit m_sym;
    bit m_und;
    bit m_done;
    bit m_strobe_q;
    int feed_mode = 0;  // 1: random bit_valid/bit_in each clock
    int act_cnt  = 0;   // observed symbol edges seen while burst_active
    int done_cnt = 0;   // observed burst_done pulses

    task automatic model_reset();
        q.delete();
        m_pos      = -1;
        m_prev     = 1'b1;
        m_sym      = 1'b0;
        m_und      = 1'b0;
        m_done     = 1'b0;
        m_strobe_q = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("next_symbol", 32'(next_symbol), 32'(m_sym));
        chk("burst_active", 32'(burst_active), 32'(m_pos >= 0));
        chk("burst_done", 32'(burst_done), 32'(m_done));
        chk("underrun", 32'(underrun), 32'(m_und));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("bit_ready", 32'(bit_ready), 32'(q.size() < DEPTH));
    endtask

    // One clock: inputs already driven, advance, update model, compare.
    task automatic step();
        bit sym_edge, can_push, do_push, idle_pre, und_ev, d, act_pre, din;
        if (feed_mode == 1) begin
            bit_valid = 1'($urandom_range(0, 1));
            bit_in    = 1'($urandom_range(0, 1));
        end
        act_pre  = burst_active;
        sym_edge = symbol_strobe && !m_strobe_q;
        can_push = (q.size() < DEPTH);
        do_push  = bit_valid && can_push;
        din      = bit_in;
        idle_pre = (m_pos < 0);
        @(posedge clock);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            m_strobe_q = symbol_strobe;
            m_done = 1'b0;
            und_ev = 1'b0;
            if (sym_edge) begin
                d = 1'b1;
                if (m_pos >= 0 && m_pos < BURST) begin
                    if (q.size() > 0) d = q.pop_front();
                    else und_ev = 1'b1;
                end
                m_sym  = DIFF ? (d ^ m_prev) : d;
                m_prev = d;
                if (act_pre) act_cnt++;
                if (m_pos >= 0) begin
                    m_pos++;
                    if (m_pos == BURST + GUARD) begin
                        m_pos  = -1;
                        m_done = 1'b1;
                    end
                end
            end
            if (idle_pre && burst_start) begin
                m_pos  = 0;
                m_prev = 1'b1;
            end
            if (do_push) q.push_back(din);
            if (underrun_clear) m_und = 1'b0;
            if (und_ev) m_und = 1'b1;
        end
        if (burst_done === 1'b1) done_cnt++;
        chk_all();
    endtask

    // One symbol period: strobe high for hi clocks, low for lo clocks.
    task automatic symbol(input int hi, input int lo, input bit clr_on_edge);
        symbol_strobe = 1'b1;
        underrun_clear = clr_on_edge;
        step();
        underrun_clear = 1'b0;
        for (int i = 1; i < hi; i++) step();
        symbol_strobe = 1'b0;
        for (int i = 0; i < lo; i++) step();
    endtask

    task automatic start_burst();
        burst_start = 1'b1;
        step();
        burst_start = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        chk("reset_next_symbol", 32'(next_symbol), 32'd0);
        chk("reset_bit_ready", 32'(bit_ready), 32'd1);
        chk("reset_fifo_level", 32'(fifo_level), 32'd0);
        chk("reset_burst_active", 32'(burst_active), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Idle fill only.
        for (int k = 0; k < 10; k++) symbol(1, 3, 1'b0);

        // Full alternating burst.
        bit_valid = 1'b1;
        for (int k = 0; k < BURST; k++) begin
            bit_in = (k % 2 == 0);
            step();
        end
        bit_valid = 1'b0;
        chk("loaded_level", 32'(fifo_level), 32'(BURST));
        act_cnt = 0;
        done_cnt = 0;
        start_burst();
        for (int k = 0; k < BURST + GUARD + 2; k++) symbol(1, 3, 1'b0);
        chk("active_symbols", 32'(act_cnt), 32'(BURST + GUARD));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("drained_level", 32'(fifo_level), 32'd0);

        // Short load, long strobe: underrun plus clear/set collision.
        bit_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            bit_in = 1'($urandom_range(0, 1));
            step();
        end
        bit_valid = 1'b0;
        act_cnt = 0;
        done_cnt = 0;
        start_burst();
        for (int k = 0; k < BURST + GUARD + 2; k++) begin
            symbol(5, 2, k == 120);
            if (k == 99) chk("no_underrun_yet", 32'(underrun), 32'd0);
            if (k == 100) chk("underrun_set", 32'(underrun), 32'd1);
            if (k == 120) chk("clear_vs_set", 32'(underrun), 32'd1);
        end
        chk("active_symbols_underrun", 32'(act_cnt), 32'(BURST + GUARD));
        chk("done_pulses_underrun", 32'(done_cnt), 32'd1);
        underrun_clear = 1'b1;
        step();
        underrun_clear = 1'b0;
        chk("underrun_cleared", 32'(underrun), 32'd0);

        // Fill to capacity, then burst with random concurrent pushes.
        bit_valid = 1'b1;
        for (int k = 0; k < DEPTH + 4; k++) begin
            bit_in = 1'($urandom_range(0, 1));
            step();
        end
        bit_valid = 1'b0;
        chk("full_level", 32'(fifo_level), 32'(DEPTH));
        chk("full_not_ready", 32'(bit_ready), 32'd0);
        start_burst();
        feed_mode = 1;
        for (int k = 0; k < BURST + GUARD + 2; k++) symbol(1, 2, 1'b0);
        feed_mode = 0;
        bit_valid = 1'b0;

        // Reset mid-payload.
        done_cnt = 0;
        start_burst();
        for (int k = 0; k < 50; k++) symbol(1, 2, 1'b0);
        reset = 1'b1;
        #1;
        model_reset();
        chk("midreset_active", 32'(burst_active), 32'd0);
        chk("midreset_level", 32'(fifo_level), 32'd0);
        chk("midreset_done", 32'(burst_done), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        for (int k = 0; k < 4; k++) symbol(1, 2, 1'b0);
        chk("midreset_no_done", 32'(done_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
